// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the RF/ALU requesters, the UART busy flag and the TX data synchronizer.
// A request is taken on any CLK edge where VLD && RDY. The requester holds VLD and its data
// until that edge. TX_D_VLD is a one-cycle strobe with no ready: it is paced only by BUSY.
interface uart_tx_arbiter_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0]   RF_DATA;
  logic                    RF_VLD;
  logic                    RF_RDY;
  logic [2*DATA_WIDTH-1:0] ALU_DATA;
  logic                    ALU_VLD;
  logic                    ALU_RDY;
  logic                    BUSY;
  logic [DATA_WIDTH-1:0]   TX_P_DATA;
  logic                    TX_D_VLD;
  logic                    TO_ERR;

  modport master (
    output RF_DATA, RF_VLD, ALU_DATA, ALU_VLD, BUSY,
    input  RF_RDY, ALU_RDY, TX_P_DATA, TX_D_VLD, TO_ERR
  );

  modport slave (
    input  RF_DATA, RF_VLD, ALU_DATA, ALU_VLD, BUSY,
    output RF_RDY, ALU_RDY, TX_P_DATA, TX_D_VLD, TO_ERR
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of the UART TX path between a one-byte RF source and a two-byte ALU source.
// Each byte is strobed once, and then paced on the synchronized BUSY flag with a timeout.
module uart_tx_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int BUSY_TO    = 16
) (
  input  logic               CLK,
  input  logic               RST,
  uart_tx_arbiter_if.slave   bus,
  output logic [1:0]         dbg_state
);
  localparam int CNT_W = $clog2(BUSY_TO);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_HI, WAIT_LO} state_t;

  state_t                  state;
  logic                    rf_full;
  logic [DATA_WIDTH-1:0]   rf_q;
  logic                    alu_full;
  logic [2*DATA_WIDTH-1:0] alu_q;
  logic                    grant_alu;
  logic                    last_alu;
  logic                    byte_idx;
  logic [CNT_W-1:0]        to_cnt;
  logic [DATA_WIDTH-1:0]   tx_data_q;
  logic                    tx_vld_q;

  logic gnt_alu;
  logic to_hit;
  logic byte_done;

  // On a tie the source that did not win last time goes first; a lone requester always wins.
  assign gnt_alu   = (rf_full && alu_full) ? !last_alu : alu_full;
  assign to_hit    = (state == WAIT_HI) && !bus.BUSY && (to_cnt == CNT_W'(BUSY_TO - 1));
  assign byte_done = to_hit || ((state == WAIT_LO) && !bus.BUSY);

  assign bus.RF_RDY    = !rf_full;
  assign bus.ALU_RDY   = !alu_full;
  assign bus.TX_P_DATA = tx_data_q;
  assign bus.TX_D_VLD  = tx_vld_q;
  assign bus.TO_ERR    = to_hit;
  assign dbg_state     = state;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      rf_full   <= 1'b0;
      rf_q      <= '0;
      alu_full  <= 1'b0;
      alu_q     <= '0;
      grant_alu <= 1'b0;
      last_alu  <= 1'b1;
      byte_idx  <= 1'b0;
      to_cnt    <= '0;
      tx_data_q <= '0;
      tx_vld_q  <= 1'b0;
    end else begin
      tx_vld_q <= 1'b0;

      if (bus.RF_VLD && !rf_full) begin
        rf_q    <= bus.RF_DATA;
        rf_full <= 1'b1;
      end
      if (bus.ALU_VLD && !alu_full) begin
        alu_q    <= bus.ALU_DATA;
        alu_full <= 1'b1;
      end

      case (state)
        IDLE: begin
          // A stale BUSY from a previous frame holds off every grant.
          if (!bus.BUSY && (rf_full || alu_full)) begin
            grant_alu <= gnt_alu;
            byte_idx  <= 1'b0;
            tx_vld_q  <= 1'b1;
            tx_data_q <= gnt_alu ? alu_q[DATA_WIDTH-1:0] : rf_q;
            state     <= LOAD;
          end
        end
        LOAD: begin
          to_cnt <= '0;
          state  <= WAIT_HI;
        end
        WAIT_HI: begin
          if (bus.BUSY) state <= WAIT_LO;
          else if (!to_hit) to_cnt <= to_cnt + CNT_W'(1);
        end
        default: ;
      endcase

      // A timed-out byte finishes the same way as one whose BUSY pulse came and went.
      if (byte_done) begin
        if (grant_alu && !byte_idx) begin
          byte_idx  <= 1'b1;
          tx_vld_q  <= 1'b1;
          tx_data_q <= alu_q[2*DATA_WIDTH-1:DATA_WIDTH];
          state     <= LOAD;
        end else begin
          state    <= IDLE;
          last_alu <= grant_alu;
          if (grant_alu) alu_full <= 1'b0;
          else rf_full <= 1'b0;
        end
      end
    end
  end
endmodule
